// File: rtl/grf_scoreboard.sv
// grf_scoreboard: operand-availability scoreboard and D-stage stall controller.
// Each GPR has a 3-bit countdown holding the remaining Tnew of its youngest
// in-flight producer; a separate counter tracks the multiply/divide busy window.
module grf_scoreboard #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int MD_CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_rs_tuse,
    input  logic [1:0]  d_rt_tuse,
    input  logic [4:0]  d_wa,
    input  logic [2:0]  d_tnew,
    input  logic [1:0]  d_md_op,
    output logic        stall,
    output logic        issue,
    output logic        md_busy,
    output logic [31:0] pend_mask
);

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_HILO = 2'd3
    } md_op_e;

    localparam logic [1:0] TUSE_NOT_READ = 2'd3;

    // cnt[0] is never loaded (writes to $0 are ignored) and resets to zero
    logic [2:0]          cnt [32];
    logic [MD_CNT_W-1:0] md_cnt;

    logic   rs_haz;
    logic   rt_haz;
    logic   md_haz;
    logic   reg_load;
    md_op_e md_op;

    assign md_op = md_op_e'(d_md_op);

    // Hazard detection from registered counters and current D-stage operands
    always_comb begin
        rs_haz = (d_rs != 5'd0) && (d_rs_tuse != TUSE_NOT_READ) &&
                 (cnt[d_rs] > {1'b0, d_rs_tuse});
        rt_haz = (d_rt != 5'd0) && (d_rt_tuse != TUSE_NOT_READ) &&
                 (cnt[d_rt] > {1'b0, d_rt_tuse});
        md_haz = (md_op != MD_NONE) && (md_cnt != '0);
    end

    // Stall/issue decision; zero latency from D inputs
    always_comb begin
        stall    = d_valid && (rs_haz || rt_haz || md_haz);
        issue    = d_valid && !stall && !flush;
        reg_load = issue && (d_wa != 5'd0) && (d_tnew != 3'd0);
    end

    // Per-register countdown; a new producer's load overrides the decrement (WAW)
    always_ff @(posedge clk) begin
        cnt[0] <= '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (reset || flush) begin
                cnt[i] <= '0;
            end else if (reg_load && (d_wa == 5'(i))) begin
                cnt[i] <= d_tnew;
            end else if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end

    // MDU busy countdown; flush lets an already-started operation finish
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (issue && (md_op == MD_MULT)) begin
            md_cnt <= MD_CNT_W'(MULT_CYC);
        end else if (issue && (md_op == MD_DIV)) begin
            md_cnt <= MD_CNT_W'(DIV_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // Debug view of which registers have a pending producer
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            pend_mask[i] = (cnt[i] != '0);
        end
        md_busy = (md_cnt != '0);
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: table-driven per-cycle vectors plus hand-written
// sequences for the MDU windows, flush and mid-operation reset.
module tb_grf_scoreboard;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        d_valid;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_rs_tuse;
    logic [1:0]  d_rt_tuse;
    logic [4:0]  d_wa;
    logic [2:0]  d_tnew;
    logic [1:0]  d_md_op;
    logic        stall;
    logic        issue;
    logic        md_busy;
    logic [31:0] pend_mask;

    int n_cmp = 0;
    int n_err = 0;

    grf_scoreboard #(.MULT_CYC(5), .DIV_CYC(10), .MD_CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .d_valid   (d_valid),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rs_tuse (d_rs_tuse),
        .d_rt_tuse (d_rt_tuse),
        .d_wa      (d_wa),
        .d_tnew    (d_tnew),
        .d_md_op   (d_md_op),
        .stall     (stall),
        .issue     (issue),
        .md_busy   (md_busy),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        v;
        logic [4:0]  rs;
        logic [1:0]  rs_u;
        logic [4:0]  rt;
        logic [1:0]  rt_u;
        logic [4:0]  wa;
        logic [2:0]  tn;
        logic [1:0]  md;
        logic        e_stall;
        logic        e_issue;
        logic        e_busy;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic fl, input logic v,
                                input logic [4:0] rs, input logic [1:0] rs_u,
                                input logic [4:0] rt, input logic [1:0] rt_u,
                                input logic [4:0] wa, input logic [2:0] tn,
                                input logic [1:0] md,
                                input logic e_stall, input logic e_issue,
                                input logic e_busy, input logic [31:0] e_mask);
        vec_t r;
        r.fl = fl; r.v = v; r.rs = rs; r.rs_u = rs_u; r.rt = rt; r.rt_u = rt_u;
        r.wa = wa; r.tn = tn; r.md = md;
        r.e_stall = e_stall; r.e_issue = e_issue; r.e_busy = e_busy; r.e_mask = e_mask;
        return r;
    endfunction

    function automatic logic [31:0] bm(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v,
                         input logic [4:0] rs, input logic [1:0] rs_u,
                         input logic [4:0] rt, input logic [1:0] rt_u,
                         input logic [4:0] wa, input logic [2:0] tn,
                         input logic [1:0] md);
        flush = fl; d_valid = v; d_rs = rs; d_rs_tuse = rs_u;
        d_rt = rt; d_rt_tuse = rt_u; d_wa = wa; d_tnew = tn; d_md_op = md;
    endtask

    task automatic nop();
        drive(0, 0, 0, 3, 0, 3, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  stalls;
        bit  done;

        // ---------------- vector table ----------------
        //           fl v  rs u  rt u  wa tn md   stl iss bsy mask
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, 32'h0));          // reset state
        // load-use
        vq.push_back(mk(0, 1, 29, 1,  0, 3,  8, 2, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 1,  8, 1,  0, 1, 10, 1, 0,  1, 0, 0, bm(8)));
        vq.push_back(mk(0, 1,  8, 1,  0, 1, 10, 1, 0,  0, 1, 0, bm(8)));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, bm(10)));
        // no hazard: addu tnew=1 then sw reading rt with tuse=2
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  8, 1, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 1, 29, 1,  8, 2,  0, 0, 0,  0, 1, 0, bm(8)));
        // $0 destination never recorded
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  0, 2, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, 32'h0));
        // not-read (tuse=3) with cnt[5]=2
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  5, 3, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, bm(5)));
        vq.push_back(mk(0, 1,  5, 3,  0, 3,  0, 0, 0,  0, 1, 0, bm(5)));
        vq.push_back(mk(0, 1,  5, 0,  0, 3,  0, 0, 0,  1, 0, 0, bm(5)));
        vq.push_back(mk(0, 1,  5, 0,  0, 3,  0, 0, 0,  0, 1, 0, 32'h0));
        // rt hazard boundary: cnt > tuse stalls, cnt == tuse issues
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  7, 3, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 1,  0, 3,  7, 2,  0, 0, 0,  1, 0, 0, bm(7)));
        vq.push_back(mk(0, 1,  0, 3,  7, 2,  0, 0, 0,  0, 1, 0, bm(7)));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, bm(7)));
        // WAW: younger tnew=1 overrides older tnew=2
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  9, 2, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  9, 1, 0,  0, 1, 0, bm(9)));
        vq.push_back(mk(0, 1,  9, 0,  0, 3,  0, 0, 0,  1, 0, 0, bm(9)));
        vq.push_back(mk(0, 1,  9, 0,  0, 3,  0, 0, 0,  0, 1, 0, 32'h0));
        // flush kills pending producer and blocks the D instruction's load
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  8, 2, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(1, 1,  8, 0,  0, 3, 12, 3, 0,  1, 0, 0, bm(8)));
        vq.push_back(mk(0, 1,  8, 0,  0, 3, 12, 3, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(1, 1,  0, 3,  0, 3, 13, 2, 0,  0, 0, 0, bm(12)));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, 32'h0));
        // no stall without d_valid
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  3, 1, 0,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0,  3, 0,  0, 3,  0, 0, 0,  0, 0, 0, bm(3)));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, 32'h0));
        // tnew = 7 (counter maximum), consumer tuse=2 stalls while cnt 7..3
        vq.push_back(mk(0, 1,  0, 3,  0, 3, 31, 7, 0,  0, 1, 0, 32'h0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0, 1, 31, 2,  0, 3,  0, 0, 0,  1, 0, 0, bm(31)));
        vq.push_back(mk(0, 1, 31, 2,  0, 3,  0, 0, 0,  0, 1, 0, bm(31)));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, bm(31)));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, 32'h0));
        // mult then mflo: busy t+1..t+5, mflo issues at t+6
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  0, 0, 1,  0, 1, 0, 32'h0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0, 1,  0, 3,  0, 3,  2, 1, 3,  1, 0, 1, 32'h0));
        vq.push_back(mk(0, 1,  0, 3,  0, 3,  2, 1, 3,  0, 1, 0, 32'h0));
        vq.push_back(mk(0, 0,  0, 3,  0, 3,  0, 0, 0,  0, 0, 0, bm(2)));

        // ---------------- reset ----------------
        reset = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table loop ----------------
        foreach (vq[i]) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].fl, vq[i].v, vq[i].rs, vq[i].rs_u, vq[i].rt, vq[i].rt_u,
                  vq[i].wa, vq[i].tn, vq[i].md);
            #1;
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vq[i].e_stall));
            chk($sformatf("v%0d issue", i), 32'(issue), 32'(vq[i].e_issue));
            chk($sformatf("v%0d md_busy", i), 32'(md_busy), 32'(vq[i].e_busy));
            chk($sformatf("v%0d pend_mask", i), pend_mask, vq[i].e_mask);
        end

        // ---------------- div: mflo stalls exactly DIV_CYC cycles ----------------
        @(negedge clk);
        drive(0, 1, 0, 3, 0, 3, 0, 0, 2);
        #1 chk("div issue", 32'(issue), 32'd1);
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            drive(0, 1, 0, 3, 0, 3, 0, 0, 3);
            #1;
            if (issue) done = 1;
            else stalls++;
        end
        chk("div mflo issued", 32'(done), 32'd1);
        chk("div stall cycles", 32'(stalls), 32'd10);

        // ---------------- flush during div ----------------
        @(negedge clk);
        drive(0, 1, 0, 3, 0, 3, 0, 0, 2);             // div starts
        #1 chk("fdiv issue", 32'(issue), 32'd1);
        @(negedge clk);
        drive(0, 1, 0, 3, 0, 3, 8, 2, 0);             // lw $8 while MDU busy
        #1 chk("fdiv lw issue", 32'(issue), 32'd1);
        @(negedge clk);
        drive(1, 1, 0, 3, 0, 3, 0, 0, 3);             // flush with mflo in D
        #1;
        chk("fdiv flush stall", 32'(stall), 32'd1);
        chk("fdiv flush mask", pend_mask, bm(8));
        chk("fdiv flush issue", 32'(issue), 32'd0);
        @(negedge clk);
        drive(0, 1, 8, 0, 0, 3, 0, 0, 0);             // $8 consumer after flush
        #1;
        chk("fdiv post mask", pend_mask, 32'h0);
        chk("fdiv post busy", 32'(md_busy), 32'd1);
        chk("fdiv post no stall", 32'(stall), 32'd0);
        @(negedge clk);
        drive(0, 1, 0, 3, 0, 3, 0, 0, 1);             // mult while div runs
        #1 chk("fdiv mult stall", 32'(stall), 32'd1);

        // ---------------- reset mid-div ----------------
        @(negedge clk);
        drive(0, 1, 0, 3, 0, 3, 4, 5, 0);
        #1 chk("rst lw issue", 32'(issue), 32'd1);
        @(negedge clk);
        nop();
        reset = 1'b1;
        #1;
        chk("rst pre busy", 32'(md_busy), 32'd1);
        chk("rst pre mask", pend_mask, bm(4));
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 4, 0, 0, 3, 0, 0, 3);
        #1;
        chk("rst post busy", 32'(md_busy), 32'd0);
        chk("rst post mask", pend_mask, 32'h0);
        chk("rst post stall", 32'(stall), 32'd0);
        chk("rst post issue", 32'(issue), 32'd1);

        @(negedge clk);
        nop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Operand-availability scoreboard and stall controller for the D stage of the 5-stage pipeline. It tracks, per general-purpose register, how many cycles remain until an in-flight producer's result can be forwarded. It also tracks the multi-cycle multiply/divide unit's busy window. Each cycle it decides whether the instruction in D may issue to E or must stall; the register file and forwarding muxes stay as they are.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu issues
- DIV_CYC, 10, busy cycles after a div/divu issues
- MD_CNT_W, 4, width of MDU busy counter; must satisfy 2^MD_CNT_W > max(MULT_CYC, DIV_CYC)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- flush  in  1  exception/eret flush; kills all in-flight E/M producers
- d_valid  in  1  D holds a real instruction
- d_rs  in  5  source register 1 address
- d_rt  in  5  source register 2 address
- d_rs_tuse  in  2  cycles until rs is consumed; 3 = not read
- d_rt_tuse  in  2  cycles until rt is consumed; 3 = not read
- d_wa  in  5  destination register; 0 = no write
- d_tnew  in  3  cycles from issue until the result is forwardable; 0 = none
- d_md_op  in  2  0 none, 1 start mult, 2 start div, 3 HI/LO access (mfhi/mflo/mthi/mtlo)
- stall  out  1  freeze PC/F/D and insert a bubble into E
- issue  out  1  d_valid && !stall && !flush
- md_busy  out  1  MDU counter non-zero
- pend_mask  out  32  bit i = cnt[i] != 0 (debug/verification)

## Operation
- State: cnt[1..31], 3 bits each; cnt[0] is constant 0. md_cnt is MD_CNT_W bits.
- Register stall: rs_haz = (d_rs != 0) && (cnt[d_rs] > d_rs_tuse). rt_haz is the same with d_rt/d_rt_tuse. A tuse of 3 never hazards because the counter maximum is 7 and the encoding 3 means "not read", so force the hazard to 0 when tuse == 3.
- MDU stall: md_haz = (d_md_op != 0) && (md_cnt != 0).
- stall = d_valid && (rs_haz || rt_haz || md_haz). Combinational from registered state and D inputs only.
- Per-cycle update, priority highest first:
  1. reset: all cnt = 0, md_cnt = 0.
  2. flush: all cnt = 0. md_cnt keeps counting; an already-started MDU operation completes. The D instruction is not issued.
  3. Otherwise, every cnt[i] != 0 decrements by 1. md_cnt != 0 decrements by 1.
  4. If issue && d_wa != 0 && d_tnew != 0: cnt[d_wa] = d_tnew. This overrides the decrement for that register, so the newer producer wins on a WAW.
  5. If issue && d_md_op == 1: md_cnt = MULT_CYC. If d_md_op == 2: md_cnt = DIV_CYC.
- An issue with d_wa == 0 or d_tnew == 0 leaves the scoreboard untouched.
- The counter value equals the remaining Tnew of the youngest producer. Decrementing models pipeline advance regardless of stall, because stall only freezes D and earlier stages.

## Timing
- Reset values: stall = 0 when d_valid = 0, issue = 0, md_busy = 0, pend_mask = 0.
- Issue in cycle t with tnew = n: cnt = n at t+1, n-1 at t+2, ..., 0 at t+n+1.
- A consumer with tuse = u stalls while cnt > u. It issues in the first cycle with cnt <= u, which is the minimum legal distance with full forwarding.
- Zero latency: stall reflects the current cycle's inputs. The issue decision and the state update happen on the same clock edge.
- Simultaneous events:
  - issue and decrement on the same register: load wins.
  - flush and d_valid: no issue, no load.
  - reset and flush: reset.
- The MDU start instruction itself does not stall on an idle MDU. A second MDU op issued at t+1 after a mult at t stalls for MULT_CYC cycles.
- Reset mid-operation clears all pending state in one cycle.

## Test plan
- Load-use: lw $t0 (wa=8, tnew=2) issues, then addu using rs=8 (tuse=1) is in D -> stall = 1 for exactly 1 cycle, issue in the following cycle; pend_mask[8] = 1 for 2 cycles.
- No hazard: addu $8 (tnew=1), then sw with rt=8 (tuse=2) -> stall never asserts.
- $0 and not-read: producer with wa=0 and tnew=2 -> pend_mask = 0. Consumer with rs=5, rs_tuse=3 while cnt[5] = 2 -> no stall.
- WAW: lw $9 (tnew=2) at t, then addu $9 (tnew=1) at t+1 -> cnt[9] = 1 at t+2. Consumer with tuse=0 stalls 1 cycle, not 2.
- MDU: mult at t -> md_busy for cycles t+1..t+5. mflo in D during that window stalls and issues at t+6. With DIV_CYC=10, div stalls mflo for 10 cycles.
- Flush: lw $8 pending (cnt[8] = 2) and flush = 1 -> cnt[8] = 0 next cycle with no stall on $8. A div in progress keeps md_busy set. Reset mid-div clears md_busy the next cycle.
